// File: rtl/mas_div_pkg.sv
// Shared types and constants for the mas_div_radix sequential divider.
// Define MAS_DIV_RADIX4_EN to retire two quotient bits per CALC cycle.
package mas_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int unsigned DIV_WIDTH_DEF = 32;

`ifdef MAS_DIV_RADIX4_EN
  localparam int unsigned DIV_BITS_PER_CYCLE = 2;
`else
  localparam int unsigned DIV_BITS_PER_CYCLE = 1;
`endif

  // CALC cycles needed for a w-bit quotient
  function automatic int unsigned div_iters(input int unsigned w);
    return w / DIV_BITS_PER_CYCLE;
  endfunction

endpackage

// File: rtl/mas_div_step.sv
// One restoring shift-subtract step: shift in a dividend bit, trial-subtract the divisor.
module mas_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   pr,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   pr_next,
  output logic             qbit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {pr, din};
    diff    = shifted - {2'b00, divisor};
    qbit    = (shifted >= {2'b00, divisor});
    pr_next = qbit ? (WIDTH+1)'(diff) : (WIDTH+1)'(shifted);
  end

endmodule

// File: rtl/mas_div_radix.sv
// Sequential unsigned 2W/W divider with divide-by-zero and quotient-overflow detection.
// Build option MAS_DIV_RADIX4_EN chains two steps per cycle (radix-4).
module mas_div_radix
  import mas_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem,
  output logic               dbz,
  output logic               ovf
);

  localparam int unsigned ITERS = div_iters(WIDTH);
  localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  div_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     pr;
  logic [WIDTH-1:0]   sh;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH:0]     pr_n;
  logic [WIDTH-1:0]   sh_n;
  logic [WIDTH-1:0]   div_hi;
  logic               q_a;

  assign div_hi = dividend[2*WIDTH-1:WIDTH];

  // sh holds unconsumed dividend bits at the top and collected quotient bits at the bottom
`ifdef MAS_DIV_RADIX4_EN
  logic [WIDTH:0] pr_a;
  logic           q_b;

  mas_div_step #(.WIDTH(WIDTH)) u_step0 (
    .pr(pr), .din(sh[WIDTH-1]), .divisor(dvs), .pr_next(pr_a), .qbit(q_a)
  );
  mas_div_step #(.WIDTH(WIDTH)) u_step1 (
    .pr(pr_a), .din(sh[WIDTH-2]), .divisor(dvs), .pr_next(pr_n), .qbit(q_b)
  );
  assign sh_n = WIDTH'({sh, q_a, q_b});
`else
  mas_div_step #(.WIDTH(WIDTH)) u_step0 (
    .pr(pr), .din(sh[WIDTH-1]), .divisor(dvs), .pr_next(pr_n), .qbit(q_a)
  );
  assign sh_n = WIDTH'({sh, q_a});
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      pr    <= '0;
      sh    <= '0;
      dvs   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      quot  <= '0;
      rem   <= '0;
      dbz   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            dvs  <= divisor;
            quot <= '0;
            rem  <= '0;
            dbz  <= 1'b0;
            ovf  <= 1'b0;
            if (divisor == '0) begin
              dbz   <= 1'b1;
              quot  <= '1;
              rem   <= dividend[WIDTH-1:0];
              state <= DONE;
              done  <= 1'b1;
            end else if (div_hi >= divisor) begin
              ovf   <= 1'b1;
              quot  <= '1;
              rem   <= dividend[WIDTH-1:0];
              state <= DONE;
              done  <= 1'b1;
            end else begin
              pr    <= {1'b0, div_hi};
              sh    <= dividend[WIDTH-1:0];
              cnt   <= CNT_W'(ITERS - 1);
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          pr  <= pr_n;
          sh  <= sh_n;
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            cnt   <= '0;
            quot  <= sh_n;
            rem   <= pr_n[WIDTH-1:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mas_div_radix.sv
// Directed self-checking bench for mas_div_radix at the default 32-bit width.
module tb_mas_div_radix;

`ifdef MAS_DIV_RADIX4_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [63:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, dbz, ovf;
  logic [31:0] quot, rem;

  int total = 0;
  int passed = 0;

  mas_div_radix dut (
    .clk(clk), .rstn(rstn), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quot(quot), .rem(rem), .dbz(dbz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Drive one start pulse; returns #1 after the accept edge
  task automatic launch(input logic [63:0] dd, input logic [31:0] dv);
    start = 1'b1; dividend = dd; divisor = dv;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Edges after accept until done is seen; busy_low records any busy=0 before done
  task automatic wait_done(output int cyc, output bit busy_low);
    cyc = 0; busy_low = 1'b0;
    while (!done && cyc < 200) begin
      if (!busy) busy_low = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, quot, rem, dbz, ovf} !== 68'd0)
      $display("FAIL reset_outputs busy=%b done=%b quot=%h rem=%h dbz=%b ovf=%b", busy, done, quot, rem, dbz, ovf);
    else passed++;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_normal(input logic [63:0] dd, input logic [31:0] dv,
                             input logic [31:0] eq, input logic [31:0] er);
    int cyc; bit bl;
    launch(dd, dv);
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || quot !== 32'd0)
      $display("FAIL accept_state busy=%b done=%b quot=%h expected 1 0 0", busy, done, quot);
    else passed++;
    wait_done(cyc, bl);
    total++;
    if (cyc !== LAT || bl)
      $display("FAIL latency got %0d edges busy_low=%b expected %0d edges busy high", cyc, bl, LAT);
    else passed++;
    total++;
    if (quot !== eq || rem !== er || dbz !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0)
      $display("FAIL result %h/%h got q=%h r=%h dbz=%b ovf=%b busy=%b expected q=%h r=%h flags 0",
               dd, dv, quot, rem, dbz, ovf, busy, eq, er);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || quot !== eq || rem !== er)
      $display("FAIL hold done=%b q=%h r=%h expected done 0 q=%h r=%h", done, quot, rem, eq, er);
    else passed++;
  endtask

  task automatic test_exception(input logic [63:0] dd, input logic [31:0] dv,
                                input logic edbz, input logic eovf, input logic [31:0] er);
    launch(dd, dv);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || quot !== 32'hFFFF_FFFF || rem !== er ||
        dbz !== edbz || ovf !== eovf)
      $display("FAIL exception %h/%h got done=%b busy=%b q=%h r=%h dbz=%b ovf=%b expected 1 0 ffffffff %h %b %b",
               dd, dv, done, busy, quot, rem, dbz, ovf, er, edbz, eovf);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || dbz !== edbz || ovf !== eovf)
      $display("FAIL exception_after done=%b busy=%b dbz=%b ovf=%b expected 0 0 %b %b", done, busy, dbz, ovf, edbz, eovf);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int cyc; bit bl;
    launch(64'd100, 32'd9);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; dividend = 64'd50; divisor = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, bl);
    total++;
    if (cyc !== LAT - 4 || quot !== 32'd11 || rem !== 32'd1)
      $display("FAIL ignore_mid_start edges=%0d q=%0d r=%0d expected edges=%0d q=11 r=1", cyc, quot, rem, LAT - 4);
    else passed++;
    launch(64'h0000_0001_0000_0000, 32'd3);
    total++;
    if (done !== 1'b0 || busy !== 1'b1 || quot !== 32'd0 || rem !== 32'd0)
      $display("FAIL b2b_accept done=%b busy=%b q=%h r=%h expected 0 1 0 0", done, busy, quot, rem);
    else passed++;
    wait_done(cyc, bl);
    total++;
    if (cyc !== LAT || bl || quot !== 32'h5555_5555 || rem !== 32'd1 || ovf !== 1'b0)
      $display("FAIL b2b_result edges=%0d busy_low=%b q=%h r=%h ovf=%b expected %0d 0 55555555 1 0",
               cyc, bl, quot, rem, ovf, LAT);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_calc;
    int cyc; bit bl; bit seen;
    launch(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
    repeat (10) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    total++;
    if ({busy, done, quot, rem, dbz, ovf} !== 68'd0)
      $display("FAIL reset_mid_calc busy=%b done=%b q=%h r=%h dbz=%b ovf=%b expected all 0", busy, done, quot, rem, dbz, ovf);
    else passed++;
    #2;
    rstn = 1'b1;
    seen = 1'b0;
    repeat (LAT + 6) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0)
      $display("FAIL aborted_op done_or_busy_seen=%b expected 0", seen);
    else passed++;
    launch(64'd1000, 32'd7);
    wait_done(cyc, bl);
    total++;
    if (cyc !== LAT || quot !== 32'd142 || rem !== 32'd6)
      $display("FAIL after_reset edges=%0d q=%0d r=%0d expected %0d q=142 r=6", cyc, quot, rem, LAT);
    else passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_normal(64'h0000_0000_0000_00E1, 32'h0000_000F, 32'h0000_000F, 32'd0);
    test_normal(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    test_normal(64'h0000_0000_FFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF);
    test_exception(64'h0000_0001_0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'd0);
    test_exception(64'h0000_0000_0000_1234, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_1234);
    test_back_to_back;
    test_reset_mid_calc;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mas_div_radix.md
# mas_div_radix

Sequential unsigned divider, 2W/W → W, the inverse of the radix multiplier datapath. Takes a double-width dividend (for example a multiplier product) and a single-width divisor. Returns quotient and remainder after an iterative shift-subtract sequence. Sits beside `mas_mul_radix_top` in the arithmetic unit and shares its operand widths.

## Interface
- `WIDTH`, default 32: divisor, quotient and remainder width. The dividend is 2*WIDTH. Must be even.
- `clk` in 1: clock; all state changes on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `start` in 1: request. Sampled only in IDLE or DONE.
- `dividend` in 2*WIDTH: unsigned numerator; captured when `start` is accepted.
- `divisor` in WIDTH: unsigned denominator; captured when `start` is accepted.
- `busy` out 1: high while in CALC.
- `done` out 1: one-cycle pulse; results are valid.
- `quot` out WIDTH: quotient. Held until the next accepted `start`.
- `rem` out WIDTH: remainder. Held until the next accepted `start`.
- `dbz` out 1: divide-by-zero flag, held with the results.
- `ovf` out 1: quotient-overflow flag, held with the results.

## Operation
- States:
  - IDLE: reset state.
  - CALC: iterating.
  - DONE: one cycle, then returns to IDLE.
- Accept: `start`=1 at an edge while in IDLE or DONE captures the operands and clears `quot`, `rem`, `dbz` and `ovf`.
  - `start` during CALC is ignored. There is no queueing.
- Exception check at accept:
  - divisor==0: `dbz`=1 and go directly to DONE.
  - Otherwise, if `dividend[2W-1:W]` >= divisor: `ovf`=1 and go directly to DONE.
  - On either exception: `quot`=all-ones, `rem`=`dividend[W-1:0]`.
- Normal path: go to CALC.
  - Partial remainder register: W+1 bits, initialised to `dividend[2W-1:W]`.
  - Shift register: initialised to `dividend[W-1:0]`.
  - Each iteration: shift the next dividend bit into the partial remainder, trial-subtract the divisor, keep the difference if it is non-negative, and shift the quotient bit (1 if kept) into the quotient.
  - Iteration counter counts down from W-1 per radix-2 step. At terminal count the next state is DONE, and `quot`/`rem` are loaded.
- Arithmetic invariants: `quot`*divisor + `rem` == dividend, and `rem` < divisor (whenever no flag is set).
- Reset at any time, including mid-CALC: state=IDLE, counter=0, and all outputs 0. An aborted operation produces no `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `quot`=0, `rem`=0, `dbz`=0, `ovf`=0.
- The accept edge is edge 0.
- Radix-2:
  - CALC occupies edges 1..W.
  - Results and state=DONE are registered at edge W.
  - `done` is high for exactly the cycle following edge W.
  - `busy` is high from after edge 0 through edge W.
- Exceptions: DONE at edge 0, so `done` is high in the cycle immediately after accept. `busy` never rises.
- Back-to-back: `start` sampled in DONE is accepted at that same edge, which is the edge where `done` falls. The next operation begins with no IDLE gap.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MAS_DIV_RADIX4_EN` defined: two quotient bits per CALC cycle. Two chained step instances are used, and the counter starts at W/2-1. The normal path finishes at edge W/2, and `done` is high in the following cycle. Exception timing and all results are identical to radix-2.
- Undefined: radix-2, one step instance, W iterations.

## Structure
- Package `mas_div_pkg`:
  - state enum `div_state_e` (IDLE, CALC, DONE)
  - default WIDTH constant
  - localparam for the iteration count per radix
- Sub-module `mas_div_step`: combinational single shift-subtract step. Inputs are the partial remainder, the incoming dividend bit and the divisor. Outputs are the next partial remainder and the quotient bit. It is instantiated once, or twice when `MAS_DIV_RADIX4_EN` is defined.

## Test plan
- dividend=0x0000_0000_0000_00E1, divisor=0x0000_000F → `quot`=0xF, `rem`=0, flags 0. `done` after W edges (W/2 edges with radix-4).
- dividend=0xFFFF_FFFE_0000_0001, divisor=0xFFFF_FFFF → `quot`=0xFFFF_FFFF, `rem`=0, `ovf`=0.
- dividend=0x0000_0001_0000_0000, divisor=0x1 → `ovf`=1, `quot`=0xFFFF_FFFF, `rem`=0. `done` in the cycle after accept, `busy` stays 0.
- divisor=0, dividend=0x1234 → `dbz`=1, `quot`=0xFFFF_FFFF, `rem`=0x1234. `done` after 1 edge.
- Re-assert `start` with new operands mid-CALC → ignored; the original result is returned. Then `start` during the `done` cycle → accepted, and a second correct result follows with no gap.
- Pulse `rstn` low at iteration 10 → all outputs 0 immediately, state IDLE, no `done`. A subsequent operation (1000/7) returns `quot`=142, `rem`=6.
